// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg
//   Shared types and constants for the APB completer memory (apb_slave_mem)
//   and its wait-state counter (apb_wait_counter).
//   Also supplies fallback values for the codebase-global `AW / `DW
//   macros when the build does not define them.
//   Optional feature macro used by the importing files: APB_WAIT_STATE_EN.

`ifndef AW
`define AW 8
`endif
`ifndef DW
`define DW 32
`endif

package apb_slave_pkg;

  // Completer protocol phase
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Wait-state counter width (supports 0..15 wait states)
  localparam int CNT_W = 4;

  // PSLVERR encodings
  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter
//   Loadable down-counter that paces APB wait states.
//   Ports:
//     pclk     in   clock, rising edge
//     preset   in   synchronous active-high reset (count -> 0)
//     load     in   load load_val (has priority over dec)
//     load_val in   CNT_W-bit value to load
//     dec      in   decrement by one; saturates at zero
//     count    out  current count
//     zero     out  count == 0

module apb_wait_counter
  import apb_slave_pkg::*;
(
  input  logic             pclk,
  input  logic             preset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Counter register: reset, load, or saturating decrement
  always_ff @(posedge pclk) begin
    if (preset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem
//   APB3 completer backed by a DEPTH x DW register file. Out-of-range word
//   indices (idx >= DEPTH) complete with PSLVERR and leave memory untouched.
//   Optional macro APB_WAIT_STATE_EN: when defined, WAIT_CYCLES wait states
//   are inserted per access using apb_wait_counter; otherwise every access
//   completes in its first PENABLE cycle.
//   Ports:
//     pclk     in   clock, rising edge
//     preset   in   synchronous active-high reset
//     psel     in   slave select
//     penable  in   access-phase strobe
//     pwrite   in   1 = write, 0 = read
//     paddr    in   word address; MSB is the bridge's slave-select bit (ignored)
//     pwdata   in   write data
//     prdata   out  read data (valid with pready; 0 for writes/errors)
//     pready   out  transfer complete, one cycle per transfer
//     pslverr  out  error response (valid with pready)
//   The memory array is not reset and keeps its contents across preset.

module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int AW          = `AW,
  parameter int DW          = `DW,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr
);

  localparam int            IW      = AW - 1;
  localparam int            MW      = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);

  state_e        state_r, state_nxt_s;
  logic [IW-1:0] idx_r;
  logic          pwrite_r;
  logic [DW-1:0] pwdata_r;
  logic          pready_r, pslverr_r;
  logic [DW-1:0] prdata_r;
  logic [DW-1:0] mem_r [DEPTH];

  logic          start_s, in_xfer_s, complete_s, mem_we_s;
  logic [IW-1:0] sel_idx_s;
  logic          sel_wr_s, sel_err_s, latched_err_s;
  logic          pready_nxt_s, pslverr_nxt_s;
  logic [DW-1:0] prdata_nxt_s;
  logic          wait_zero_s, cnt_last_s;
  logic          unused_slave_sel_s;

  assign unused_slave_sel_s = paddr[AW-1];

  // A new transfer starts on a setup phase seen from IDLE, or directly after
  // a completing access when the next setup is already on the bus.
  assign start_s    = psel & ~penable &
                      ((state_r == IDLE) | ((state_r == ACCESS) & pready_r));
  assign in_xfer_s  = (state_r != IDLE);
  assign complete_s = in_xfer_s & psel & penable & pready_r;

  // On the start edge the latches are not yet loaded, so use the live bus.
  assign sel_idx_s     = start_s ? paddr[IW-1:0] : idx_r;
  assign sel_wr_s      = start_s ? pwrite : pwrite_r;
  assign sel_err_s     = ({1'b0, sel_idx_s} >= DEPTH_L);
  assign latched_err_s = ({1'b0, idx_r} >= DEPTH_L);

  // Reset wins over a write completing on the same edge.
  assign mem_we_s = complete_s & pwrite_r & ~latched_err_s & ~preset;

`ifdef APB_WAIT_STATE_EN
  logic [CNT_W-1:0] cnt_s;
  logic             cnt_zero_s;

  apb_wait_counter u_wait_counter (
    .pclk     (pclk),
    .preset   (preset),
    .load     (start_s),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .dec      (in_xfer_s & psel & ~start_s & ~cnt_zero_s),
    .count    (cnt_s),
    .zero     (cnt_zero_s)
  );

  assign wait_zero_s = (WAIT_CYCLES == 0);
  // pready is registered, so it is raised on the edge where the count hits 0.
  assign cnt_last_s  = (cnt_s == {{(CNT_W-1){1'b0}}, 1'b1});
`else
  localparam int wait_cycles_unused = WAIT_CYCLES;
  assign wait_zero_s = 1'b1;
  assign cnt_last_s  = 1'b0;
`endif

  // Next-state logic. With zero wait states the transfer completes in SETUP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nxt_s = SETUP;
        else         state_nxt_s = IDLE;
      end
      SETUP: begin
        if (!psel || complete_s) state_nxt_s = IDLE;
        else                     state_nxt_s = ACCESS;
      end
      ACCESS: begin
        if (!psel)         state_nxt_s = IDLE;
        else if (start_s)  state_nxt_s = SETUP;
        else if (pready_r) state_nxt_s = IDLE;
        else               state_nxt_s = ACCESS;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Response generation: prdata/pslverr are only non-zero alongside pready.
  always_comb begin
    pready_nxt_s = 1'b0;
    if (start_s) begin
      pready_nxt_s = wait_zero_s;
    end else if (in_xfer_s && psel && !pready_r && cnt_last_s) begin
      pready_nxt_s = 1'b1;
    end else begin
      pready_nxt_s = 1'b0;
    end
    pslverr_nxt_s = (pready_nxt_s && sel_err_s) ? RESP_ERR : RESP_OKAY;
    if (pready_nxt_s && !sel_wr_s && !sel_err_s) begin
      prdata_nxt_s = mem_r[sel_idx_s[MW-1:0]];
    end else begin
      prdata_nxt_s = {DW{1'b0}};
    end
  end

  // State, transfer latches and registered outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r   <= IDLE;
      idx_r     <= {IW{1'b0}};
      pwrite_r  <= 1'b0;
      pwdata_r  <= {DW{1'b0}};
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= {DW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      pready_r  <= pready_nxt_s;
      pslverr_r <= pslverr_nxt_s;
      prdata_r  <= prdata_nxt_s;
      if (start_s) begin
        idx_r    <= paddr[IW-1:0];
        pwrite_r <= pwrite;
        pwdata_r <= pwdata;
      end else begin
        idx_r    <= idx_r;
        pwrite_r <= pwrite_r;
        pwdata_r <= pwdata_r;
      end
    end
  end

  // Register-file write port (no reset: contents survive preset)
  always_ff @(posedge pclk) begin
    if (mem_we_s) begin
      mem_r[idx_r[MW-1:0]] <= pwdata_r;
    end
  end

  assign prdata  = prdata_r;
  assign pready  = pready_r;
  assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem
//   Directed test for apb_slave_mem. A driver issues APB transfers and pushes
//   the expected response into a queue; a monitor pops and compares whenever
//   pready is seen. Works with and without APB_WAIT_STATE_EN.

`ifndef AW
`define AW 8
`endif
`ifndef DW
`define DW 32
`endif

module tb_apb_slave_mem;

  localparam int AW    = `AW;
  localparam int DW    = `DW;
  localparam int DEPTH = 64;
`ifdef APB_WAIT_STATE_EN
  localparam int WAITP    = 2;
  localparam int EXP_WAIT = 2;
`else
  localparam int WAITP    = 5;
  localparam int EXP_WAIT = 0;
`endif

  logic          pclk = 1'b0;
  logic          preset;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  apb_slave_mem #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAITP)
  ) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   ready_seen = 0;
  int   n_xfer = 0;
  int   cyc = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every pready cycle must match the oldest outstanding expectation
  always @(negedge pclk) begin
    if (preset === 1'b0 && pready === 1'b1) begin
      ready_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pready", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_rdata"}, 64'(prdata), 64'(mon_e.data));
        chk({mon_e.name, "_err"}, 64'(pslverr), 64'(mon_e.err));
      end
    end
  end

  // Entered and left at posedge+1; leaves psel low so a following call is back-to-back.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] erd, input logic eerr, input string nm);
    int n;
    exp_q.push_back('{erd, eerr, nm});
    n_xfer++;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 1;
    @(negedge pclk);
    while (pready !== 1'b1 && n < 40) begin
      @(negedge pclk);
      n++;
    end
    chk({nm, "_access_len"}, 64'(n), 64'(EXP_WAIT + 1));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_pslverr", 64'(pslverr), 64'd0);
    chk("rst_prdata", 64'(prdata), 64'd0);
    preset = 1'b0;
    idle(1);

    // penable without a preceding setup phase is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk("idle_penable_pready", 64'(pready), 64'd0);
    end
    psel = 1'b0; penable = 1'b0;
    idle(1);

    // Basic write / read, slave-select MSB ignored
    xfer(1'b1, 8'd5, 32'h0000_00A5, 32'h0, 1'b0, "wr5");
    idle(1);
    xfer(1'b0, 8'd5, 32'h0, 32'h0000_00A5, 1'b0, "rd5");
    idle(1);
    xfer(1'b0, 8'h85, 32'h0, 32'h0000_00A5, 1'b0, "rd5_selbit");
    idle(1);

    // Range boundary: 63 valid, 64 and 127 out of range
    xfer(1'b1, 8'd63, 32'h0000_3F3F, 32'h0, 1'b0, "wr63");
    xfer(1'b1, 8'd0, 32'h0000_1234, 32'h0, 1'b0, "wr0");
    idle(1);
    xfer(1'b0, 8'd64, 32'h0, 32'h0, 1'b1, "rd64");
    xfer(1'b1, 8'd64, 32'h0000_DEAD, 32'h0, 1'b1, "wr64");
    xfer(1'b0, 8'd127, 32'h0, 32'h0, 1'b1, "rd127");
    idle(1);
    xfer(1'b0, 8'd63, 32'h0, 32'h0000_3F3F, 1'b0, "rd63");
    xfer(1'b0, 8'd0, 32'h0, 32'h0000_1234, 1'b0, "rd0");
    idle(1);

    // Back-to-back write then read of the same word, no gap cycle
    c0 = cyc;
    xfer(1'b1, 8'd3, 32'h0000_0011, 32'h0, 1'b0, "b2b_wr3");
    xfer(1'b0, 8'd3, 32'h0, 32'h0000_0011, 1'b0, "b2b_rd3");
    c1 = cyc;
    chk("b2b_cycles", 64'(c1 - c0), 64'(2 * (EXP_WAIT + 2)));
    idle(1);

    // Reset during the access phase of a write drops the write
    xfer(1'b1, 8'd9, 32'h0000_0099, 32'h0, 1'b0, "wr9");
    idle(1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9; pwdata = 32'h0000_0077;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1;
    chk("rst_mid_outputs", 64'({pready, pslverr, prdata}), 64'd0);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    idle(2);
    xfer(1'b0, 8'd9, 32'h0, 32'h0000_0099, 1'b0, "rd9_after_rst");
    xfer(1'b0, 8'd5, 32'h0, 32'h0000_00A5, 1'b0, "rd5_persist");
    idle(3);

    chk("pready_count", 64'(ready_seen), 64'(n_xfer));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
